axi_wr_arbiter: RTL and testbench
=================================

// Module: axi_wr_arbiter
// PURPOSE
// Round-robin arbiter sharing one AXI write path (AW+W) between NUM_REQ write requesters
// (e.g. cache line writeback, uncached write-through). Locks grant for a whole transaction:
// AW handshake plus W burst through wlast. Sits upstream of the AW/W merger.
// Forwards the granted requester's channels combinationally; arbitration decision is registered.
// PARAMETERS
// NUM_REQ    2   number of requesters (>=2)
// IDX_W      $clog2(NUM_REQ)   derived localparam, grant index width
// PORTS
// clk        in   1                  clock
// rst_n      in   1                  async active-low reset
// s_aw       in   NUM_REQ x aw_chan_t   per-requester {awaddr,awid,awburst,awsize,awlen}
// s_awvalid  in   NUM_REQ            per-requester AW valid
// s_awready  out  NUM_REQ            per-requester AW ready
// s_w        in   NUM_REQ x w_chan_t    per-requester {wdata,wstrb,wlast}
// s_wvalid   in   NUM_REQ            per-requester W valid
// s_wready   out  NUM_REQ            per-requester W ready
// m_aw       out  aw_chan_t          merged AW payload
// m_awvalid  out  1                  merged AW valid
// m_awready  in   1                  merged AW ready
// m_w        out  w_chan_t           merged W payload
// m_wvalid   out  1                  merged W valid
// m_wready   in   1                  merged W ready
// grant_idx  out  IDX_W              index of current owner (valid while busy)
// busy       out  1                  transaction in progress
// proto_err  out  1                  sticky: wlast disagrees with awlen beat count
// BEHAVIOUR
// - Reset: state=IDLE, busy=0, grant_idx=0, rr pointer=0, proto_err=0, all valid/ready outs=0.
// - States: IDLE, XFER. Flags aw_done, w_done; beat counter beat_cnt[8:0]; latched len_q[7:0].
// - IDLE: if any s_awvalid, pick first set bit at/after rr pointer (wrap at NUM_REQ-1 -> 0);
//   next cycle: XFER, busy=1, grant_idx=winner, aw_done=0, w_done=0, beat_cnt=0.
//   Arbitration latency exactly 1 cycle; no handshake occurs in IDLE (all s_*ready=0).
// - XFER: m_aw=s_aw[g]; m_awvalid=s_awvalid[g]&!aw_done; s_awready[g]=m_awready&!aw_done.
//   m_w=s_w[g]; m_wvalid=s_wvalid[g]&!w_done; s_wready[g]=m_wready&!w_done. Non-granted readys=0.
// - AW handshake: aw_done<=1, len_q<=awlen. W may complete beats before AW handshake.
// - W handshake: beat_cnt++; on wlast: w_done<=1.
// - Exit: when (aw_done|AW hs) and (w_done|wlast hs) -> IDLE, rr pointer<=grant_idx+1 (wrap).
//   AW hs and final wlast hs in same cycle exits same cycle. Back-to-back grants: 1 idle cycle min.
// - proto_err set when at exit beat_cnt_final != len_q_final+1 (len from AW hs if same cycle);
//   also if beat_cnt reaches 256 without wlast. Cleared only by reset.
// - Valid/payload stability: granted payload passes through unmodified; owner may not change in XFER.
// - Requester raising awvalid while another owns the path waits; no starvation under rr.
// - Reset mid-XFER: immediate return to IDLE, all outputs to reset values, transaction abandoned.
// - NUM_REQ not power of 2: pointer wraps explicitly at NUM_REQ-1, never indexes past it.
// STRUCTURE
// - axi_cache_pkg: ADDR_WIDTH=32, DATA_WIDTH=64, ID_WIDTH=4, aw_chan_t, w_chan_t,
//   wr_arb_state_e {IDLE,XFER}.
// - Sub-module rr_arbiter (#NUM_REQ): req vector + pointer -> one-hot grant + index, combinational.
// - FSM, counters, flags and muxing stay in axi_wr_arbiter.
// TESTING
// - Single req0, awlen=3, 4 beats, ready always 1 -> grant_idx=0, 4 W beats out, busy drops, err=0.
// - req0,req1 awvalid same cycle from reset -> req0 served first, then req1; next tie -> req0 after req1.
// - req1 sends all W beats (awlen=1) before m_awready asserts -> W passes, exit on AW hs, err=0.
// - awlen=3 but wlast on beat 2 -> proto_err=1 at exit, stays 1 until rst_n low.
// - AW hs and final wlast same cycle, m_wready toggling 1/0 -> no lost/dup beats; IDLE next cycle.
// - rst_n low mid-burst (beat 2 of 8) -> m_awvalid=m_wvalid=0, busy=0, rr=0; fresh grant works.

Source files
------------

// File: rtl/axi_cache_pkg.sv
// rtl/axi_cache_pkg.sv - shared AXI write-channel types for the cache write path
package axi_cache_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int ID_WIDTH   = 4;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [ID_WIDTH-1:0]   awid;
    logic [1:0]            awburst;
    logic [2:0]            awsize;
    logic [7:0]            awlen;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
  } w_chan_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } wr_arb_state_e;
endpackage

// File: rtl/axi_wr_arbiter_if.sv
// rtl/axi_wr_arbiter_if.sv - requester-side and merged-side AW/W channels of the write arbiter
interface axi_wr_arbiter_if #(parameter int NUM_REQ = 2);
  import axi_cache_pkg::*;

  aw_chan_t [NUM_REQ-1:0] s_aw;
  logic     [NUM_REQ-1:0] s_awvalid;
  logic     [NUM_REQ-1:0] s_awready;
  w_chan_t  [NUM_REQ-1:0] s_w;
  logic     [NUM_REQ-1:0] s_wvalid;
  logic     [NUM_REQ-1:0] s_wready;

  aw_chan_t m_aw;
  logic     m_awvalid;
  logic     m_awready;
  w_chan_t  m_w;
  logic     m_wvalid;
  logic     m_wready;

  modport slave (
    input  s_aw, s_awvalid, s_w, s_wvalid, m_awready, m_wready,
    output s_awready, s_wready, m_aw, m_awvalid, m_w, m_wvalid
  );

  modport master (
    output s_aw, s_awvalid, s_w, s_wvalid, m_awready, m_wready,
    input  s_awready, s_wready, m_aw, m_awvalid, m_w, m_wvalid
  );
endinterface

// File: rtl/axi_wr_arbiter_rr.sv
// rtl/axi_wr_arbiter_rr.sv - combinational round-robin pick: first request at/after the pointer
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);
  int cand;

  // Scan from farthest to nearest so the nearest request at/after ptr wins last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - round-robin AW+W write arbiter; grant held from AW request through wlast
module axi_wr_arbiter
  import axi_cache_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_wr_arbiter_if.slave      bus,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic                 proto_err
);
  wr_arb_state_e      state_q, state_d;
  logic [IDX_W-1:0]   grant_q, rr_q, win_idx, grant_inc;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_any;
  logic               aw_done, w_done;
  logic [8:0]         beat_cnt, beat_next;
  logic [7:0]         len_q, len_final;
  logic               aw_hs, w_hs, wlast_hs, xfer_exit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.s_awvalid),
    .ptr     (rr_q),
    .gnt     (win_onehot),
    .gnt_idx (win_idx)
  );

  assign win_any = |win_onehot;

  always_comb begin
    bus.m_aw      = bus.s_aw[grant_q];
    bus.m_w       = bus.s_w[grant_q];
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.s_awready = '0;
    bus.s_wready  = '0;
    if (state_q == XFER) begin
      bus.m_awvalid          = bus.s_awvalid[grant_q] & ~aw_done;
      bus.m_wvalid           = bus.s_wvalid[grant_q] & ~w_done;
      bus.s_awready[grant_q] = bus.m_awready & ~aw_done;
      bus.s_wready[grant_q]  = bus.m_wready & ~w_done;
    end
  end

  assign aw_hs     = bus.m_awvalid & bus.m_awready;
  assign w_hs      = bus.m_wvalid & bus.m_wready;
  assign wlast_hs  = w_hs & bus.m_w.wlast;
  assign beat_next = beat_cnt + {8'd0, w_hs};
  // Length comes straight from the AW payload when AW completes in the exit cycle.
  assign len_final = aw_hs ? bus.m_aw.awlen : len_q;
  assign xfer_exit = (state_q == XFER) & (aw_done | aw_hs) & (w_done | wlast_hs);
  assign grant_inc = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any) state_d = XFER;
      XFER:    if (xfer_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      rr_q      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      beat_cnt  <= '0;
      len_q     <= '0;
      proto_err <= 1'b0;
    end else if (state_q == IDLE) begin
      if (win_any) begin
        grant_q  <= win_idx;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        beat_cnt <= '0;
      end
    end else begin
      if (aw_hs) begin
        aw_done <= 1'b1;
        len_q   <= bus.m_aw.awlen;
      end
      if (w_hs)     beat_cnt <= beat_next;
      if (wlast_hs) w_done   <= 1'b1;
      if (w_hs && !wlast_hs && beat_next == 9'd256) proto_err <= 1'b1;
      if (xfer_exit) begin
        rr_q <= grant_inc;
        if (beat_next != ({1'b0, len_final} + 9'd1)) proto_err <= 1'b1;
      end
    end
  end

  assign busy      = (state_q == XFER);
  assign grant_idx = grant_q;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - scoreboard bench for the round-robin AW+W write arbiter
module tb_axi_wr_arbiter;
  import axi_cache_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IDX_W-1:0] grant_idx;
  logic busy, proto_err;

  always #5 clk = ~clk;

  axi_wr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  axi_wr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .grant_idx (grant_idx),
    .busy      (busy),
    .proto_err (proto_err)
  );

  int       n_cmp = 0;
  int       n_mis = 0;
  aw_chan_t exp_aw[$];
  int       exp_gnt[$];
  w_chan_t  exp_w[$];
  int       w_seen = 0;
  bit       exit_chk = 0;
  bit       same_seen = 0;
  bit       drv_done = 0;
  logic [NUM_REQ-1:0] gmask;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic aw_chan_t mk_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    mk_aw = aw_chan_t'{awaddr: addr, awid: id, awburst: 2'b01, awsize: 3'd3, awlen: len};
  endfunction

  task automatic expect_txn(input int r, input aw_chan_t aw, input int nbeats, input logic [63:0] base);
    exp_aw.push_back(aw);
    exp_gnt.push_back(r);
    for (int b = 0; b < nbeats; b++)
      exp_w.push_back(w_chan_t'{wdata: base + 64'(b), wstrb: '1, wlast: (b == nbeats - 1)});
  endtask

  // Monitor: outputs are sampled mid-cycle; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exit_chk) begin
        check("idle_after_exit", busy, 0);
        exit_chk = 0;
      end
      if (busy) begin
        gmask = '0;
        gmask[grant_idx] = 1'b1;
        check("nongrant_ready", (bus.s_awready | bus.s_wready) & ~gmask, 0);
      end else begin
        check("idle_quiet", {bus.s_awready, bus.s_wready, bus.m_awvalid, bus.m_wvalid}, 0);
      end
      if (bus.m_awvalid && bus.m_awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          check("aw_payload", bus.m_aw, exp_aw.pop_front());
          check("aw_grant", grant_idx, exp_gnt.pop_front());
        end
      end
      if (bus.m_wvalid && bus.m_wready) begin
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else check("w_payload", bus.m_w, exp_w.pop_front());
        w_seen++;
      end
      if (bus.m_awvalid && bus.m_awready && bus.m_wvalid && bus.m_wready && bus.m_w.wlast) begin
        exit_chk  = 1;
        same_seen = 1;
      end
    end
  end

  task automatic wait_ready(input int r, input bit is_w, output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!rst_n) return;
      if (is_w ? bus.s_wready[r] : bus.s_awready[r]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("hs_timeout", 0, 1);
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int r, input aw_chan_t aw, input int nbeats, input logic [63:0] base);
    fork
      begin
        bit ok;
        bus.s_aw[r]      = aw;
        bus.s_awvalid[r] = 1'b1;
        wait_ready(r, 1'b0, ok);
        bus.s_awvalid[r] = 1'b0;
      end
      begin
        bit ok;
        ok = 1;
        for (int b = 0; b < nbeats && ok; b++) begin
          bus.s_w[r]      = w_chan_t'{wdata: base + 64'(b), wstrb: '1, wlast: (b == nbeats - 1)};
          bus.s_wvalid[r] = 1'b1;
          wait_ready(r, 1'b1, ok);
        end
        bus.s_wvalid[r] = 1'b0;
      end
    join
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy && exp_aw.size() == 0 && exp_w.size() == 0) break;
    end
    check(tag, {busy, 8'(exp_aw.size()), 8'(exp_w.size())}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.s_aw      = '0;
    bus.s_w       = '0;
    bus.s_awvalid = '0;
    bus.s_wvalid  = '0;
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    repeat (3) @(posedge clk);
    exp_aw.delete();
    exp_gnt.delete();
    exp_w.delete();
    w_seen   = 0;
    exit_chk = 0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aw_chan_t a0, a1;

    // Reset values, with requests already pending.
    rst_n         = 1'b0;
    bus.s_aw      = '0;
    bus.s_w       = '0;
    bus.s_awvalid = 2'b11;
    bus.s_wvalid  = 2'b11;
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", {busy, grant_idx, proto_err, bus.m_awvalid, bus.m_wvalid}, 0);
    check("rst_readys", {bus.s_awready, bus.s_wready}, 0);
    do_reset();

    // Single requester, awlen=3, 4 beats, one-cycle arbitration latency.
    a0 = mk_aw(32'h1000, 4'h1, 8'd3);
    expect_txn(0, a0, 4, 64'hA000);
    fork
      drive_req(0, a0, 4, 64'hA000);
      begin
        @(negedge clk);
        check("arb_lat_idle", {busy, bus.s_awready[0]}, 0);
        @(negedge clk);
        check("arb_lat_grant", {busy, grant_idx}, 2'b10);
      end
    join
    wait_idle("t1_drain");
    check("t1_err", proto_err, 0);

    // Ties from reset: req0 then req1, and the next tie goes to req0 again.
    do_reset();
    for (int round = 0; round < 2; round++) begin
      a0 = mk_aw(32'h2000 + 32'(round * 256), 4'h2, 8'd1);
      a1 = mk_aw(32'h3000 + 32'(round * 256), 4'h3, 8'd2);
      expect_txn(0, a0, 2, 64'hB000 + 64'(round * 16));
      expect_txn(1, a1, 3, 64'hC000 + 64'(round * 16));
      fork
        drive_req(0, a0, 2, 64'hB000 + 64'(round * 16));
        drive_req(1, a1, 3, 64'hC000 + 64'(round * 16));
      join
      wait_idle("t2_drain");
    end

    // req1 finishes all W beats before AW is accepted.
    a1 = mk_aw(32'h4000, 4'h5, 8'd1);
    expect_txn(1, a1, 2, 64'hD000);
    bus.m_awready = 1'b0;
    w_seen = 0;
    fork
      drive_req(1, a1, 2, 64'hD000);
      begin
        for (int c = 0; c < 50 && w_seen < 2; c++) @(negedge clk);
        check("t3_w_before_aw", w_seen, 2);
        @(posedge clk);
        #1;
        check("t3_still_busy", busy, 1);
        bus.m_awready = 1'b1;
      end
    join
    wait_idle("t3_drain");
    check("t3_err", proto_err, 0);

    // Short burst: awlen=3 with wlast on beat 2; error is sticky until reset.
    a0 = mk_aw(32'h5000, 4'h6, 8'd3);
    expect_txn(0, a0, 2, 64'hE000);
    drive_req(0, a0, 2, 64'hE000);
    wait_idle("t4_drain");
    check("t4_err_set", proto_err, 1);
    a1 = mk_aw(32'h5100, 4'h7, 8'd0);
    expect_txn(1, a1, 1, 64'hE100);
    drive_req(1, a1, 1, 64'hE100);
    wait_idle("t4_drain2");
    check("t4_err_sticky", proto_err, 1);
    do_reset();
    check("t4_err_cleared", proto_err, 0);

    // AW and final wlast handshake together while m_wready toggles.
    a0 = mk_aw(32'h6000, 4'h8, 8'd3);
    expect_txn(0, a0, 4, 64'hF000);
    w_seen = 0;
    same_seen = 0;
    drv_done = 0;
    bus.m_awready = 1'b0;
    fork
      begin
        drive_req(0, a0, 4, 64'hF000);
        drv_done = 1;
      end
      begin
        for (int c = 0; c < 100 && !drv_done; c++) begin
          @(posedge clk);
          #1;
          bus.m_wready  = ~bus.m_wready;
          bus.m_awready = (w_seen >= 3) ? bus.m_wready : 1'b0;
        end
      end
    join
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    wait_idle("t5_drain");
    check("t5_same_cycle", same_seen, 1);
    check("t5_err", proto_err, 0);

    // Reset during beat 2 of 8 on req1, then a fresh tie must go to req0.
    a1 = mk_aw(32'h7000, 4'h9, 8'd7);
    expect_txn(1, a1, 8, 64'h1_0000);
    w_seen = 0;
    fork
      drive_req(1, a1, 8, 64'h1_0000);
      begin
        for (int c = 0; c < 50 && w_seen < 2; c++) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", {bus.m_awvalid, bus.m_wvalid, busy, grant_idx, proto_err}, 0);
      end
    join
    do_reset();
    a0 = mk_aw(32'h8000, 4'hA, 8'd0);
    a1 = mk_aw(32'h9000, 4'hB, 8'd1);
    expect_txn(0, a0, 1, 64'h2_0000);
    expect_txn(1, a1, 2, 64'h3_0000);
    fork
      drive_req(0, a0, 1, 64'h2_0000);
      drive_req(1, a1, 2, 64'h3_0000);
    join
    wait_idle("t6_drain");
    check("t6_err", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
